// File: rtl/zork_pkg.sv
// Shared definitions for the movement-command path and the navigation FSM.
package zork_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_QUALIFY      = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } qual_state_e;

    localparam int unsigned CMD_IDLE     = 0;
    localparam int unsigned DIR_N        = 1;
    localparam int unsigned DIR_E        = 2;
    localparam int unsigned DIR_S        = 3;
    localparam int unsigned DIR_W        = 4;
    localparam int unsigned DIR_UP       = 5;
    localparam int unsigned DIR_DOWN     = 6;

    // Stability counter width; covers STABLE_CYCLES up to 255.
    localparam int unsigned STABLE_CNT_W = 8;

endpackage

// File: rtl/game_cmd_fifo.sv
// Show-ahead command FIFO; a push while full is accepted only if a pop happens in the same cycle.
module game_cmd_fifo #(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/game_control_buffered.sv
// Movement command qualifier (stability filter, one command per press) feeding a buffered valid/ready output.
module game_control_buffered
    import zork_pkg::*;
#(
    parameter  int unsigned CMD_W         = 4,
    parameter  int unsigned STABLE_CYCLES = 3,
    parameter  int unsigned DEPTH         = 4,
    parameter  int unsigned DROP_W        = 8,
    localparam int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic              clk_50MHz_i,
    input  logic              rst_sync_la_i,
    input  logic [CMD_W-1:0]  movement_i,
    output logic [CMD_W-1:0]  direction_o,
    output logic              dir_valid_o,
    input  logic              dir_ready_i,
    output logic [CNT_W-1:0]  fifo_count_o,
    output logic [DROP_W-1:0] drop_count_o,
    output logic              busy_o
);

    qual_state_e             state_q;
    qual_state_e             state_d;
    logic [CMD_W-1:0]        cand_q;
    logic [CMD_W-1:0]        cand_d;
    logic [STABLE_CNT_W-1:0] cnt_q;
    logic [STABLE_CNT_W-1:0] cnt_d;
    logic                    push_c;
    logic                    busy_q;
    logic [DROP_W-1:0]       drop_q;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop_c;

    always_ff @(posedge clk_50MHz_i) begin
        if (!rst_sync_la_i) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // The push fires on the edge that takes the STABLE_CYCLES-th matching sample.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        push_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (movement_i != CMD_W'(CMD_IDLE)) begin
                    cand_d = movement_i;
                    cnt_d  = STABLE_CNT_W'(1);
                    if (STABLE_CYCLES == 1) begin
                        push_c  = 1'b1;
                        state_d = ST_WAIT_RELEASE;
                    end else begin
                        state_d = ST_QUALIFY;
                    end
                end
            end
            ST_QUALIFY: begin
                if (movement_i == cand_q) begin
                    cnt_d = cnt_q + STABLE_CNT_W'(1);
                    if ((cnt_q + STABLE_CNT_W'(1)) == STABLE_CNT_W'(STABLE_CYCLES)) begin
                        push_c  = 1'b1;
                        state_d = ST_WAIT_RELEASE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (movement_i == CMD_W'(CMD_IDLE)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop_c       = dir_ready_i && !fifo_empty;
    assign dir_valid_o = !fifo_empty;
    assign busy_o      = busy_q;
    assign drop_count_o = drop_q;

    // A push into a full FIFO survives only when the head leaves in the same cycle.
    always_ff @(posedge clk_50MHz_i) begin
        if (!rst_sync_la_i) begin
            drop_q <= '0;
        end else if (push_c && fifo_full && !pop_c && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    game_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_50MHz_i),
        .rst_n (rst_sync_la_i),
        .push  (push_c),
        .din   (cand_d),
        .pop   (pop_c),
        .dout  (direction_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_o)
    );

endmodule

// File: tb/tb_game_control_buffered.sv
// Randomised and directed bench for game_control_buffered against a press/queue reference model.
module tb_game_control_buffered;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned STABLE = 3;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned OBS_W  = CMD_W + 1 + CNT_W + DROP_W + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CMD_W-1:0]  movement;
    logic [CMD_W-1:0]  direction;
    logic              dir_valid;
    logic              dir_ready;
    logic [CNT_W-1:0]  fifo_count;
    logic [DROP_W-1:0] drop_count;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of accepted commands plus the current press's progress.
    logic [CMD_W-1:0] m_q[$];
    int unsigned      m_drop;
    int unsigned      m_run;
    logic [CMD_W-1:0] m_code;
    bit               m_locked;

    game_control_buffered #(
        .CMD_W         (CMD_W),
        .STABLE_CYCLES (STABLE),
        .DEPTH         (DEPTH),
        .DROP_W        (DROP_W)
    ) dut (
        .clk_50MHz_i   (clk),
        .rst_sync_la_i (rst_n),
        .movement_i    (movement),
        .direction_o   (direction),
        .dir_valid_o   (dir_valid),
        .dir_ready_i   (dir_ready),
        .fifo_count_o  (fifo_count),
        .drop_count_o  (drop_count),
        .busy_o        (busy)
    );

    always #10 clk = ~clk;

    function automatic logic [OBS_W-1:0] observed();
        return {direction, dir_valid, fifo_count, drop_count, busy};
    endfunction

    function automatic logic [OBS_W-1:0] expected();
        logic [CMD_W-1:0] head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        return {head, (m_q.size() != 0), CNT_W'(m_q.size()), DROP_W'(m_drop),
                (m_locked || m_run != 0)};
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, settle past it.
    task automatic step(input logic r, input logic [CMD_W-1:0] mv, input logic rdy);
        bit pop;
        bit push;
        rst_n     = r;
        movement  = mv;
        dir_ready = rdy;
        @(posedge clk);
        if (!r) begin
            m_q.delete();
            m_drop   = 0;
            m_run    = 0;
            m_code   = '0;
            m_locked = 0;
        end else begin
            pop  = (m_q.size() != 0) && rdy;
            push = 0;
            if (m_locked) begin
                if (mv == 0) m_locked = 0;
            end else if (m_run == 0) begin
                if (mv != 0) begin
                    m_code = mv;
                    m_run  = 1;
                end
            end else if (mv == m_code) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run == STABLE) begin
                push     = 1;
                m_run    = 0;
                m_locked = 1;
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_code);
                else if (m_drop < (2 ** DROP_W) - 1) m_drop++;
            end
        end
        #1;
    endtask

    task automatic press(input logic [CMD_W-1:0] code, input int len);
        for (int i = 0; i < len; i++) step(1'b1, code, 1'b0);
        step(1'b1, '0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        checks++;
        if (observed() !== OBS_W'(0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", observed());
        end
    endtask

    task automatic test_single_press();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'h6, 1'b0);
            checks++;
            if ({dir_valid, direction} !== {(i >= 2), (i >= 2) ? 4'h6 : 4'h0}) begin
                errors++;
                $display("FAIL single_press cyc%0d: valid=%b dir=%h", i, dir_valid, direction);
            end
        end
        step(1'b1, '0, 1'b0);
        checks++;
        if ({fifo_count, busy} !== {CNT_W'(1), 1'b0} || observed() !== expected()) begin
            errors++;
            $display("FAIL single_press_count: got %h expected %h", observed(), expected());
        end
        step(1'b1, '0, 1'b1);
    endtask

    task automatic test_glitch();
        step(1'b1, 4'h6, 1'b0);
        step(1'b1, 4'h6, 1'b0);
        step(1'b1, 4'h3, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b1, 4'h6, 1'b0);
        step(1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0);
        checks++;
        if (fifo_count !== '0 || dir_valid !== 1'b0 || observed() !== expected()) begin
            errors++;
            $display("FAIL glitch: count=%0d valid=%b expected count 0", fifo_count, dir_valid);
        end
    endtask

    task automatic test_overflow();
        logic [CMD_W-1:0] exp_dir;
        for (int c = 1; c <= 6; c++) press(CMD_W'(c), 3);
        checks++;
        if (fifo_count !== CNT_W'(4) || drop_count !== DROP_W'(2)) begin
            errors++;
            $display("FAIL overflow_counts: count=%0d drop=%0d expected 4/2", fifo_count, drop_count);
        end
        for (int i = 0; i < 4; i++) begin
            exp_dir = CMD_W'(i + 1);
            checks++;
            if (direction !== exp_dir || dir_valid !== 1'b1) begin
                errors++;
                $display("FAIL overflow_drain%0d: dir=%h expected %h", i, direction, exp_dir);
            end
            step(1'b1, '0, 1'b1);
        end
        checks++;
        if (dir_valid !== 1'b0 || drop_count !== DROP_W'(2)) begin
            errors++;
            $display("FAIL overflow_empty: valid=%b drop=%0d", dir_valid, drop_count);
        end
    endtask

    task automatic test_full_pop();
        logic [CMD_W-1:0] exp_dir;
        step(1'b0, '0, 1'b0);
        for (int c = 1; c <= 4; c++) press(CMD_W'(c), 3);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h5, 1'b1);
        checks++;
        if (fifo_count !== CNT_W'(4) || drop_count !== '0 || observed() !== expected()) begin
            errors++;
            $display("FAIL full_pop: count=%0d drop=%0d expected 4/0", fifo_count, drop_count);
        end
        step(1'b1, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_dir = CMD_W'(i + 2);
            checks++;
            if (direction !== exp_dir) begin
                errors++;
                $display("FAIL full_pop_drain%0d: dir=%h expected %h", i, direction, exp_dir);
            end
            step(1'b1, '0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, '0, 1'b0);
        press(4'h1, 3);
        press(4'h2, 3);
        step(1'b1, 4'h6, 1'b0);
        step(1'b1, 4'h6, 1'b0);
        checks++;
        if (fifo_count !== CNT_W'(2) || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: count=%0d busy=%b expected 2/1", fifo_count, busy);
        end
        step(1'b0, 4'h6, 1'b1);
        checks++;
        if (observed() !== OBS_W'(0)) begin
            errors++;
            $display("FAIL reset_mid: got %h expected 0", observed());
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'h6, 1'b0);
            checks++;
            if (dir_valid !== (i == 2) || observed() !== expected()) begin
                errors++;
                $display("FAIL reset_mid_requal%0d: got %h expected %h", i, observed(), expected());
            end
        end
        step(1'b1, '0, 1'b1);
    endtask

    task automatic test_random();
        logic [CMD_W-1:0] mv;
        int hold;
        logic r;
        mv   = '0;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                mv   = ($urandom_range(0, 2) == 0) ? '0 : CMD_W'($urandom_range(1, 3));
                hold = $urandom_range(1, 5);
            end
            hold--;
            r = ($urandom_range(0, 99) != 0);
            step(r, mv, ($urandom_range(0, 3) == 0));
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL random cyc%0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        m_drop   = 0;
        m_run    = 0;
        m_code   = '0;
        m_locked = 0;
        rst_n     = 1'b0;
        movement  = '0;
        dir_ready = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
